// File: rtl/operand_fwd.sv
// Operand resolve/forward stage after the rv32i register file read port.
// Applies EX/MEM/WB bypass, tracks outstanding loads and registers resolved operands for EX.
module operand_fwd #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREG   = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              FLUSH,
   input  logic              STALL,
   input  logic              I_VALID,
   input  logic [4:0]        I_RS1,
   input  logic [DATA_W-1:0] I_RS1_V,
   input  logic [4:0]        I_RS2,
   input  logic [DATA_W-1:0] I_RS2_V,
   input  logic [4:0]        I_RD,
   input  logic              I_RD_WE,
   input  logic              I_IS_LOAD,
   input  logic              EX_VALID,
   input  logic [4:0]        EX_RD,
   input  logic [DATA_W-1:0] EX_V,
   input  logic              MEM_VALID,
   input  logic [4:0]        MEM_RD,
   input  logic [DATA_W-1:0] MEM_V,
   input  logic [4:0]        WB_RD,
   input  logic [DATA_W-1:0] WB_V,
   input  logic              LD_DONE,
   input  logic [4:0]        LD_DONE_RD,
   output logic              HAZARD_STALL,
   output logic              O_VALID,
   output logic [DATA_W-1:0] O_RS1_V,
   output logic [DATA_W-1:0] O_RS2_V,
   output logic [4:0]        O_RD,
   output logic              O_RD_WE,
   output logic              O_IS_LOAD
);

   logic [NREG-1:0]   r_pend;
   logic [NREG-1:0]   w_pend_eff;
   logic [NREG-1:0]   w_clr;
   logic [NREG-1:0]   w_set;
   logic [NREG-1:0]   w_pend_d;
   logic [DATA_W-1:0] w_rs1_v;
   logic [DATA_W-1:0] w_rs2_v;
   logic              w_hazard;
   logic              w_accept;

   // Youngest producer wins; WB is needed because the register file writes on the same edge.
   function automatic logic [DATA_W-1:0] f_resolve(
      input logic [4:0]        idx,
      input logic [DATA_W-1:0] rf_v,
      input logic              ex_vld,
      input logic [4:0]        ex_rd,
      input logic [DATA_W-1:0] ex_v,
      input logic              mem_vld,
      input logic [4:0]        mem_rd,
      input logic [DATA_W-1:0] mem_v,
      input logic [4:0]        wb_rd,
      input logic [DATA_W-1:0] wb_v
   );
      logic [DATA_W-1:0] v;
      if (idx == 5'd0)                      v = '0;
      else if (ex_vld && ex_rd == idx)      v = ex_v;
      else if (mem_vld && mem_rd == idx)    v = mem_v;
      else if (wb_rd == idx)                v = wb_v;
      else                                  v = rf_v;
      return v;
   endfunction

   always_comb begin
      w_rs1_v = f_resolve(I_RS1, I_RS1_V, EX_VALID, EX_RD, EX_V, MEM_VALID, MEM_RD, MEM_V,
                          WB_RD, WB_V);
      w_rs2_v = f_resolve(I_RS2, I_RS2_V, EX_VALID, EX_RD, EX_V, MEM_VALID, MEM_RD, MEM_V,
                          WB_RD, WB_V);
   end

   always_comb begin
      w_clr = '0;
      if (LD_DONE) w_clr[LD_DONE_RD] = 1'b1;
      w_pend_eff = r_pend & ~w_clr;
      w_hazard   = RST && I_VALID && !FLUSH &&
                   (w_pend_eff[I_RS1] || w_pend_eff[I_RS2] || (I_RD_WE && w_pend_eff[I_RD]));
      w_accept   = !FLUSH && !STALL && !w_hazard;
      w_set      = '0;
      if (w_accept && I_VALID && I_RD_WE && I_IS_LOAD && I_RD != 5'd0) w_set[I_RD] = 1'b1;
      // Set after clear so a new load to the same register stays outstanding.
      w_pend_d    = (r_pend & ~w_clr) | w_set;
      w_pend_d[0] = 1'b0;
   end

   assign HAZARD_STALL = w_hazard;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST || FLUSH) begin
         O_VALID   <= 1'b0;
         O_RS1_V   <= '0;
         O_RS2_V   <= '0;
         O_RD      <= '0;
         O_RD_WE   <= 1'b0;
         O_IS_LOAD <= 1'b0;
      end else if (STALL) begin
         O_VALID   <= O_VALID;
      end else if (w_hazard) begin
         O_VALID   <= 1'b0;
         O_RD_WE   <= 1'b0;
         O_IS_LOAD <= 1'b0;
      end else begin
         O_VALID   <= I_VALID;
         O_RS1_V   <= w_rs1_v;
         O_RS2_V   <= w_rs2_v;
         O_RD      <= I_RD;
         O_RD_WE   <= I_RD_WE;
         O_IS_LOAD <= I_IS_LOAD;
      end
   end

endmodule

// File: tb/tb_operand_fwd.sv
// Directed self-checking bench for operand_fwd: reset, bypass priority, load-use,
// scoreboard set/clear collisions, flush/stall and rd=0 loads.
module tb_operand_fwd;

   logic        CLK = 1'b0;
   logic        RST, FLUSH, STALL, I_VALID, I_RD_WE, I_IS_LOAD;
   logic [4:0]  I_RS1, I_RS2, I_RD, EX_RD, MEM_RD, WB_RD, LD_DONE_RD;
   logic [31:0] I_RS1_V, I_RS2_V, EX_V, MEM_V, WB_V;
   logic        EX_VALID, MEM_VALID, LD_DONE;
   logic        HAZARD_STALL, O_VALID, O_RD_WE, O_IS_LOAD;
   logic [31:0] O_RS1_V, O_RS2_V;
   logic [4:0]  O_RD;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   operand_fwd #(.DATA_W(32), .NREG(32)) dut (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .STALL(STALL), .I_VALID(I_VALID),
      .I_RS1(I_RS1), .I_RS1_V(I_RS1_V), .I_RS2(I_RS2), .I_RS2_V(I_RS2_V),
      .I_RD(I_RD), .I_RD_WE(I_RD_WE), .I_IS_LOAD(I_IS_LOAD),
      .EX_VALID(EX_VALID), .EX_RD(EX_RD), .EX_V(EX_V),
      .MEM_VALID(MEM_VALID), .MEM_RD(MEM_RD), .MEM_V(MEM_V),
      .WB_RD(WB_RD), .WB_V(WB_V), .LD_DONE(LD_DONE), .LD_DONE_RD(LD_DONE_RD),
      .HAZARD_STALL(HAZARD_STALL), .O_VALID(O_VALID), .O_RS1_V(O_RS1_V),
      .O_RS2_V(O_RS2_V), .O_RD(O_RD), .O_RD_WE(O_RD_WE), .O_IS_LOAD(O_IS_LOAD)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      FLUSH = 0; STALL = 0; I_VALID = 0; I_RD_WE = 0; I_IS_LOAD = 0;
      I_RS1 = 0; I_RS2 = 0; I_RD = 0; I_RS1_V = 0; I_RS2_V = 0;
      EX_VALID = 0; EX_RD = 0; EX_V = 0; MEM_VALID = 0; MEM_RD = 0; MEM_V = 0;
      WB_RD = 0; WB_V = 0; LD_DONE = 0; LD_DONE_RD = 0;
   endtask

   task automatic load_op(input logic [4:0] rd);
      I_VALID = 1; I_RD = rd; I_RD_WE = 1; I_IS_LOAD = 1; I_RS1 = 0; I_RS2 = 0;
   endtask

   initial begin
      idle_inputs();
      // 1. reset
      RST = 0; I_VALID = 1; I_RS1 = 3; I_RS1_V = 32'h11;
      #1 chk("rst_hazard", HAZARD_STALL, 0);
      tick(); tick();
      chk("rst_valid", O_VALID, 0);
      chk("rst_rs1", O_RS1_V, 0);
      chk("rst_pend", dut.r_pend, 0);
      RST = 1;
      tick();
      chk("post_rst_valid", O_VALID, 1);
      chk("post_rst_rs1", O_RS1_V, 32'h11);

      // 2. bypass priority
      I_RS1 = 5; I_RS1_V = 32'h99; I_RS2 = 5; I_RS2_V = 32'h98;
      EX_VALID = 1; EX_RD = 5; EX_V = 32'hA;
      MEM_VALID = 1; MEM_RD = 5; MEM_V = 32'hB;
      WB_RD = 5; WB_V = 32'hC;
      tick();
      chk("byp_ex", O_RS1_V, 32'hA);
      chk("byp_ex_rs2", O_RS2_V, 32'hA);
      EX_VALID = 0;
      tick();
      chk("byp_mem", O_RS1_V, 32'hB);
      MEM_VALID = 0;
      tick();
      chk("byp_wb", O_RS1_V, 32'hC);
      WB_RD = 0;
      tick();
      chk("byp_rf", O_RS1_V, 32'h99);
      I_RS1 = 0; I_RS1_V = 32'h77; EX_VALID = 1; EX_RD = 0;
      tick();
      chk("byp_x0", O_RS1_V, 0);
      idle_inputs();

      // 3. load-use
      load_op(7);
      tick();
      chk("ld7_valid", O_VALID, 1);
      chk("ld7_isload", O_IS_LOAD, 1);
      chk("ld7_pend", dut.r_pend, 32'h80);
      I_RD = 8; I_IS_LOAD = 0; I_RS2 = 7; I_RS2_V = 32'h1;
      #1 chk("lu_hazard", HAZARD_STALL, 1);
      tick();
      chk("lu_bubble_valid", O_VALID, 0);
      chk("lu_bubble_we", O_RD_WE, 0);
      chk("lu_hazard2", HAZARD_STALL, 1);
      tick();
      chk("lu_bubble2", O_VALID, 0);
      LD_DONE = 1; LD_DONE_RD = 7; WB_RD = 7; WB_V = 32'h55;
      #1 chk("lu_done_nohaz", HAZARD_STALL, 0);
      tick();
      chk("lu_valid", O_VALID, 1);
      chk("lu_rs2", O_RS2_V, 32'h55);
      chk("lu_pend", dut.r_pend, 0);
      idle_inputs();
      tick();

      // 4. simultaneous set/clear, WAW
      load_op(9);
      tick();
      chk("ld9_pend", dut.r_pend, 32'h200);
      LD_DONE = 1; LD_DONE_RD = 9;
      #1 chk("setclr_nohaz", HAZARD_STALL, 0);
      tick();
      chk("setclr_pend", dut.r_pend, 32'h200);
      chk("setclr_valid", O_VALID, 1);
      LD_DONE = 0; I_IS_LOAD = 0; I_RD = 9; I_RD_WE = 1;
      #1 chk("waw_hazard", HAZARD_STALL, 1);
      tick();
      chk("waw_bubble", O_VALID, 0);
      LD_DONE = 1; LD_DONE_RD = 9;
      tick();
      chk("waw_go_valid", O_VALID, 1);
      chk("waw_go_rd", O_RD, 9);
      chk("waw_pend", dut.r_pend, 0);
      idle_inputs();

      // 5. stall and flush
      I_VALID = 1; I_RS1 = 3; I_RS1_V = 32'h33; I_RS2 = 4; I_RS2_V = 32'h44;
      I_RD = 10; I_RD_WE = 1;
      tick();
      chk("cap_rs1", O_RS1_V, 32'h33);
      STALL = 1; I_RS1_V = 32'hEE; I_RD = 11;
      tick(); tick(); tick();
      chk("stall_rs1", O_RS1_V, 32'h33);
      chk("stall_rs2", O_RS2_V, 32'h44);
      chk("stall_rd", O_RD, 10);
      chk("stall_valid", O_VALID, 1);
      FLUSH = 1;
      tick();
      chk("flush_stall_valid", O_VALID, 0);
      chk("flush_stall_rd", O_RD, 0);
      idle_inputs();
      load_op(12);
      tick();
      chk("ld12_pend", dut.r_pend, 32'h1000);
      load_op(13); I_RS1 = 12; FLUSH = 1;
      #1 chk("flush_nohaz", HAZARD_STALL, 0);
      tick();
      chk("flush_keep_pend", dut.r_pend, 32'h1000);
      chk("flush_valid", O_VALID, 0);
      idle_inputs();
      LD_DONE = 1; LD_DONE_RD = 12;
      tick();
      chk("ld12_done", dut.r_pend, 0);
      LD_DONE_RD = 3;
      tick();
      chk("spurious_done", dut.r_pend, 0);
      idle_inputs();

      // 6. load to x0
      load_op(0);
      tick();
      chk("ldx0_pend", dut.r_pend, 0);
      I_IS_LOAD = 0; I_RD = 1; I_RS1 = 0; I_RS1_V = 32'h5A;
      #1 chk("ldx0_nohaz", HAZARD_STALL, 0);
      tick();
      chk("ldx0_valid", O_VALID, 1);
      chk("ldx0_rs1", O_RS1_V, 0);

      // reset mid-operation with a load outstanding
      load_op(5);
      tick();
      chk("ld5_pend", dut.r_pend, 32'h20);
      I_IS_LOAD = 0; I_RS1 = 5; RST = 0; FLUSH = 1; LD_DONE = 1; LD_DONE_RD = 6;
      #1 chk("rst_mid_hazard", HAZARD_STALL, 0);
      tick();
      chk("rst_mid_pend", dut.r_pend, 0);
      chk("rst_mid_valid", O_VALID, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/operand_fwd.md
Name: operand_fwd

Overview:
- Pipeline stage directly downstream of the rv32i register file read port.
- Takes the registered source indices and values from the register file, plus the decoded instruction attributes.
- Applies EX, MEM and WB bypass, tracks outstanding loads in a 32-entry scoreboard, and stalls upstream on hazards.
- Presents registered, fully resolved operands to the execute stage.

Parameters:
DATA_W, 32, operand/result width
NREG, 32, architectural register count (index width fixed at 5)

Ports:
CLK  in  1  clock
RST  in  1  reset
FLUSH  in  1  kill the instruction in this stage and the output register
STALL  in  1  downstream stall; hold the output register
I_VALID  in  1  instruction present (aligned with the register file read outputs)
I_RS1  in  5  source A index (register file REG_IR_O_A)
I_RS1_V  in  DATA_W  source A value (register file REG_IR_O_AV)
I_RS2  in  5  source B index (register file REG_IR_O_B)
I_RS2_V  in  DATA_W  source B value (register file REG_IR_O_BV)
I_RD  in  5  destination index
I_RD_WE  in  1  instruction writes rd
I_IS_LOAD  in  1  instruction is a load (result arrives later)
EX_VALID  in  1  EX stage holds a non-load rd write
EX_RD  in  5  EX destination
EX_V  in  DATA_W  EX result
MEM_VALID  in  1  MEM stage holds a non-load rd write
MEM_RD  in  5  MEM destination
MEM_V  in  DATA_W  MEM result
WB_RD  in  5  register file write index (same as REG_IW_I_A)
WB_V  in  DATA_W  register file write data (same as REG_IW_I_AV)
LD_DONE  in  1  load completion pulse, coincident with its WB write
LD_DONE_RD  in  5  destination of the completing load
HAZARD_STALL  out  1  combinational; upstream must hold its inputs
O_VALID  out  1  registered; operands valid for EX
O_RS1_V  out  DATA_W  resolved source A
O_RS2_V  out  DATA_W  resolved source B
O_RD  out  5  passed-through destination
O_RD_WE  out  1  passed-through write enable
O_IS_LOAD  out  1  passed-through load flag

Behaviour:
- Clocking and reset: one clock CLK; reset RST is synchronous and active-low.
- While RST=0 at a posedge:
  - all O_* outputs go to 0 (O_VALID=0, O_RS1_V=0, O_RS2_V=0, O_RD=0, O_RD_WE=0, O_IS_LOAD=0);
  - scoreboard pend[31:0] is cleared to 0.
- HAZARD_STALL is 0 during reset.
- Operand resolution (combinational), per source, first match wins:
  1. index==0 -> 0;
  2. EX_VALID && EX_RD==idx -> EX_V;
  3. MEM_VALID && MEM_RD==idx -> MEM_V;
  4. WB_RD==idx (WB_RD != 0) -> WB_V;
  5. otherwise the register file value.
- Rule 4 is required because the register file commits at the same posedge that this stage samples.
- Hazard (combinational): HAZARD_STALL = I_VALID && !FLUSH && (pend_eff[I_RS1] || pend_eff[I_RS2] || (I_RD_WE && pend_eff[I_RD])).
  - pend_eff = pend with the LD_DONE_RD bit cleared when LD_DONE=1. A load completing this cycle is resolved through WB forwarding.
  - pend[0] is never set.
- Output register update, per posedge, in priority order:
  1. FLUSH -> O_VALID<=0, other O_* <= 0.
  2. STALL -> hold all O_*.
  3. HAZARD_STALL -> bubble: O_VALID<=0, O_RD_WE<=0, O_IS_LOAD<=0.
  4. Otherwise -> O_VALID<=I_VALID and capture the resolved operands and attributes.
- Latency: 1 cycle from an accepted input to O_VALID.
- Upstream must also hold its inputs while STALL=1. HAZARD_STALL does not include STALL; the top level ORs them.
- Scoreboard:
  - set pend[I_RD] on case 4 when I_VALID && I_RD_WE && I_IS_LOAD && I_RD != 0;
  - clear pend[LD_DONE_RD] on LD_DONE;
  - same index set and clear in one cycle -> set wins (new load outstanding).
- FLUSH does not clear pend; already-issued loads still complete.
- A flushed instruction never sets pend.
- LD_DONE for a register that is not pending is ignored.
- Reset mid-operation: everything returns to its reset values at the next posedge, regardless of FLUSH, STALL or LD_DONE.

Test Plan:
1. Reset: RST=0 for 2 cycles with I_VALID=1 -> O_VALID=0, O_RS1_V=0, pend=0. RST=1 with I_RS1=3, I_RS1_V=0x11 -> next cycle O_VALID=1, O_RS1_V=0x11.
2. Bypass priority: I_RS1=5 with EX_RD=5/EX_V=0xA, MEM_RD=5/MEM_V=0xB, WB_RD=5/WB_V=0xC -> O_RS1_V=0xA. Drop EX_VALID -> 0xB. Drop MEM_VALID -> 0xC. I_RS1=0 with EX_RD=0 -> 0.
3. Load-use:
   - issue load rd=7 -> pend[7]=1;
   - next instruction rs2=7 -> HAZARD_STALL=1, O_VALID=0 each cycle;
   - LD_DONE, LD_DONE_RD=7, WB_RD=7, WB_V=0x55 -> HAZARD_STALL=0 that cycle, O_RS2_V=0x55 next cycle, pend[7]=0.
4. Simultaneous set and clear: LD_DONE_RD=9 in the same cycle a new load with rd=9 is accepted -> pend[9]=1 afterwards. WAW check: a load to rd=9 followed by an ALU op writing rd=9 -> stalls.
5. FLUSH and STALL:
   - STALL=1 for 3 cycles -> O_* frozen;
   - FLUSH and STALL together -> O_VALID=0;
   - FLUSH while a load is pending -> pend bit retained;
   - a flushed load input does not set pend.
6. Load rd=0 -> pend stays 0, no hazard on a following rs1=0.
